// File: rtl/ov7670_frame_tx_pkg.sv
// Shared definitions for the OV7670 frame emulator: FSM state codes, pattern
// codes, the colour-bar RGB565 table and small constant helpers.
// Ports: none (package).
package ov7670_frame_tx_pkg;

  // FSM state encodings
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_VSYNC  = 3'd1;
  localparam logic [2:0] ST_VBP    = 3'd2;
  localparam logic [2:0] ST_ACTIVE = 3'd3;
  localparam logic [2:0] ST_VFP    = 3'd4;

  // Test pattern selectors
  localparam logic [1:0] PAT_BARS  = 2'd0;
  localparam logic [1:0] PAT_SOLID = 2'd1;
  localparam logic [1:0] PAT_GRAD  = 2'd2;
  localparam logic [1:0] PAT_CNT   = 2'd3;

  // Colour-bar table, left to right
  localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
  localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
  localparam logic [15:0] BAR_CYAN    = 16'h07FF;
  localparam logic [15:0] BAR_GREEN   = 16'h07E0;
  localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
  localparam logic [15:0] BAR_RED     = 16'hF800;
  localparam logic [15:0] BAR_BLUE    = 16'h001F;
  localparam logic [15:0] BAR_BLACK   = 16'h0000;

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

  // Bits needed for a counter running 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/ov7670_frame_tx_pattern_gen.sv
// Purpose: combinational test-pattern source, maps (pattern, x, y) to RGB565.
// Latency: zero (pure combinational); no backpressure, always produces a word.
// Ports: pattern_i selector, x_i pixel index, y_i active line index, rgb_o word.
module ov7670_frame_tx_pattern_gen
  import ov7670_frame_tx_pkg::*;
#(
  parameter int unsigned H_PIXELS = 160,
  parameter logic [15:0] SOLID    = 16'hF800
) (
  input  logic [1:0]  pattern_i,
  input  logic [15:0] x_i,
  input  logic [15:0] y_i,
  output logic [15:0] rgb_o
);

  logic [2:0] bar_idx;

  // Eight equal-width bars across the active width.
  assign bar_idx = 3'((32'(x_i) * 32'd8) / 32'(H_PIXELS));

  always_comb begin
    rgb_o = 16'h0000;
    case (pattern_i)
      PAT_BARS:  rgb_o = bar_color(bar_idx);
      PAT_SOLID: rgb_o = SOLID;
      PAT_GRAD:  rgb_o = {x_i[4:0], x_i[5:0], x_i[4:0]};
      PAT_CNT:   rgb_o = 16'(32'(x_i) + 32'(y_i) * 32'(H_PIXELS));
    endcase
  end

endmodule

// File: rtl/ov7670_frame_tx.sv
// Purpose: OV7670 DVP bus emulator producing vsync/href/px_data test frames.
// Latency: enable sampled in IDLE -> vsync high one clock later; all outputs registered.
// Backpressure: none; free-running at one byte per clk, frames never truncated.
// Ports: clk_i, rst_i (sync, active high), enable_i, pattern_i in;
//        vsync_o, href_o, px_data_o, frame_done_o out.
module ov7670_frame_tx
  import ov7670_frame_tx_pkg::*;
#(
  parameter int unsigned H_PIXELS  = 160,
  parameter int unsigned V_LINES   = 120,
  parameter int unsigned H_BLANK   = 16,
  parameter int unsigned VSYNC_LEN = 3,
  parameter int unsigned V_BP      = 2,
  parameter int unsigned V_FP      = 2,
  parameter logic [15:0] SOLID     = 16'hF800
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       enable_i,
  input  logic [1:0] pattern_i,
  output logic       vsync_o,
  output logic       href_o,
  output logic [7:0] px_data_o,
  output logic       frame_done_o
);

  localparam int unsigned LINE_LEN = 2 * H_PIXELS + H_BLANK;
  localparam int unsigned ROW_MAX  = max4(VSYNC_LEN, V_BP, V_LINES, V_FP);
  localparam int unsigned COL_W    = cnt_w(LINE_LEN);
  localparam int unsigned ROW_W    = cnt_w(ROW_MAX);

  localparam logic [COL_W-1:0] COL_LAST   = COL_W'(LINE_LEN - 1);
  localparam logic [COL_W-1:0] COL_ACTIVE = COL_W'(2 * H_PIXELS);

  logic [2:0]       state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [ROW_W-1:0] row_last;
  logic [1:0]       pattern_q, pattern_d;
  logic [15:0]      frame_cnt_q;

  logic        vsync_d, href_d, done_d;
  logic [7:0]  px_d;
  logic [15:0] rgb;

  // Last row index of the phase currently being timed.
  always_comb begin
    row_last = '0;
    case (state_q)
      ST_VSYNC:  row_last = ROW_W'(VSYNC_LEN - 1);
      ST_VBP:    row_last = ROW_W'(V_BP - 1);
      ST_ACTIVE: row_last = ROW_W'(V_LINES - 1);
      ST_VFP:    row_last = ROW_W'(V_FP - 1);
      default:   row_last = '0;
    endcase
  end

  // Frame FSM and col/row counters. The pattern is captured only on entry
  // to VSYNC so a mid-frame change never tears the image.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    pattern_d = pattern_q;
    if (state_q == ST_IDLE) begin
      col_d = '0;
      row_d = '0;
      if (enable_i) begin
        state_d   = ST_VSYNC;
        pattern_d = pattern_i;
      end
    end else if (col_q != COL_LAST) begin
      col_d = col_q + 1'b1;
    end else begin
      col_d = '0;
      if (row_q != row_last) begin
        row_d = row_q + 1'b1;
      end else begin
        row_d = '0;
        case (state_q)
          ST_VSYNC:  state_d = ST_VBP;
          ST_VBP:    state_d = ST_ACTIVE;
          ST_ACTIVE: state_d = ST_VFP;
          ST_VFP: begin
            if (enable_i) begin
              state_d   = ST_VSYNC;
              pattern_d = pattern_i;
            end else begin
              state_d = ST_IDLE;
            end
          end
          default:   state_d = ST_IDLE;
        endcase
      end
    end
  end

  // Outputs are decoded from the next-state values and registered, so they
  // line up with the state they describe without an extra cycle of delay.
  ov7670_frame_tx_pattern_gen #(
    .H_PIXELS (H_PIXELS),
    .SOLID    (SOLID)
  ) u_pattern_gen (
    .pattern_i (pattern_d),
    .x_i       (16'(col_d >> 1)),
    .y_i       (16'(row_d)),
    .rgb_o     (rgb)
  );

  always_comb begin
    vsync_d = (state_d == ST_VSYNC);
    href_d  = (state_d == ST_ACTIVE) && (col_d < COL_ACTIVE);
    px_d    = 8'h00;
    if (href_d) begin
      // High byte on even columns, low byte on odd.
      px_d = col_d[0] ? rgb[7:0] : rgb[15:8];
    end
    done_d  = (state_d == ST_VFP) && (row_d == ROW_W'(V_FP - 1)) && (col_d == COL_LAST);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      pattern_q    <= PAT_BARS;
      frame_cnt_q  <= 16'h0000;
      vsync_o      <= 1'b0;
      href_o       <= 1'b0;
      px_data_o    <= 8'h00;
      frame_done_o <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      pattern_q    <= pattern_d;
      vsync_o      <= vsync_d;
      href_o       <= href_d;
      px_data_o    <= px_d;
      frame_done_o <= done_d;
      // Debug-only frame count; wraps naturally at 16 bits.
      if (done_d) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_ov7670_frame_tx.sv
// Directed bench for ov7670_frame_tx with a small frame geometry:
// LINE_LEN=10, frame = 60 clocks (VSYNC 1..10, VBP 11..20, ACTIVE 21..50, VFP 51..60).
module tb_ov7670_frame_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [1:0] pattern = 2'd0;
  logic       vsync, href, frame_done;
  logic [7:0] px_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ov7670_frame_tx #(
    .H_PIXELS  (4),
    .V_LINES   (3),
    .H_BLANK   (2),
    .VSYNC_LEN (1),
    .V_BP      (1),
    .V_FP      (1),
    .SOLID     (16'hF800)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .enable_i     (enable),
    .pattern_i    (pattern),
    .vsync_o      (vsync),
    .href_o       (href),
    .px_data_o    (px_data),
    .frame_done_o (frame_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hand-computed RGB565 words for H_PIXELS=4.
  function automatic logic [15:0] exp_word(input int pat, input int x, input int y);
    logic [15:0] w;
    w = 16'h0000;
    case (pat)
      0: case (x)  // bars 0,2,4,6: white, cyan, magenta, blue
           0: w = 16'hFFFF;
           1: w = 16'h07FF;
           2: w = 16'hF81F;
           default: w = 16'h001F;
         endcase
      1: w = 16'hF800;
      2: case (x)
           0: w = 16'h0000;
           1: w = 16'h0821;
           2: w = 16'h1042;
           default: w = 16'h1863;
         endcase
      default: w = 16'(x + 4 * y);
    endcase
    return w;
  endfunction

  // Walks one frame clock by clock (k=1 is the clock after enable is sampled).
  task automatic run_frame(input int pat, input int last_k, input int drop_at,
                           input int sw_at, input logic [1:0] sw_pat);
    int c, line, hcnt, dcnt;
    logic vs, hr, dn;
    logic [7:0] b;
    logic [15:0] w;
    hcnt = 0;
    dcnt = 0;
    for (int k = 1; k <= last_k; k++) begin
      tick();
      vs = (k <= 10);
      hr = 1'b0;
      b  = 8'h00;
      if (k >= 21 && k <= 50) begin
        c    = (k - 21) % 10;
        line = (k - 21) / 10;
        if (c < 8) begin
          hr = 1'b1;
          w  = exp_word(pat, c / 2, line);
          b  = c[0] ? w[7:0] : w[15:8];
        end
      end
      dn = (k == 60);
      check($sformatf("p%0d_k%0d", pat, k), {21'd0, vsync, href, px_data, frame_done},
            {21'd0, vs, hr, b, dn});
      hcnt += int'(href);
      dcnt += int'(frame_done);
      if (k == drop_at) enable = 1'b0;
      if (k == sw_at)   pattern = sw_pat;
    end
    if (last_k == 60) begin
      check($sformatf("p%0d_href_bytes", pat), hcnt, 24);
      check($sformatf("p%0d_done_cnt", pat), dcnt, 1);
    end
  endtask

  task automatic check_idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check($sformatf("%s_%0d", tag, i), {21'd0, vsync, href, px_data, frame_done}, 32'd0);
    end
  endtask

  initial begin
    repeat (3) tick();
    check("reset_outs", {21'd0, vsync, href, px_data, frame_done}, 32'd0);
    rst = 1'b0;
    check_idle("idle", 20);

    // Solid frame; pattern changed to 3 mid-frame only affects the next frame.
    pattern = 2'd1;
    enable  = 1'b1;
    run_frame(1, 60, 0, 25, 2'd3);
    // Back-to-back counter frame; switch to bars mid-frame.
    run_frame(3, 60, 0, 25, 2'd0);
    // Bars frame; enable dropped in line 2 of ACTIVE, frame still completes.
    run_frame(0, 60, 33, 0, 2'd0);
    check_idle("after_drop", 15);

    // Reset during href-high of active line 1.
    pattern = 2'd2;
    enable  = 1'b1;
    run_frame(2, 33, 0, 0, 2'd0);
    rst = 1'b1;
    tick();
    check("rst_mid_vsync_href", {30'd0, vsync, href}, 32'd0);
    tick();
    check("rst_hold", {21'd0, vsync, href, px_data, frame_done}, 32'd0);
    rst = 1'b0;
    // Fresh frame with the one-clock start latency; stop after it.
    run_frame(2, 60, 55, 0, 2'd0);
    check_idle("final_idle", 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
